// File: rtl/controle_escrita_banco.sv
// controle_escrita_banco
// Write-back sequencer in front of the register bank. Three producers
// (memory load, jump-and-link, ULA) compete for a small FIFO under fixed
// priority memory > jal > ula. The FIFO drains one entry per cycle onto the
// bank's single write port. The module also exports a per-register pending
// vector so upstream logic can check for hazards.
// Optional feature: define ESCRITA_BYPASS_EN so that a transfer arriving at an
// empty, idle FIFO is written straight to the bank in the same cycle.
module controle_escrita_banco #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valido,
  input  logic [31:0] mem_dado,
  input  logic [8:0]  mem_reg,
  output logic        mem_pronto,
  input  logic        jal_valido,
  input  logic [31:0] jal_pc,
  input  logic [8:0]  jal_reg,
  output logic        jal_pronto,
  input  logic        ula_valido,
  input  logic [31:0] ula_dado,
  input  logic [8:0]  ula_reg,
  output logic        ula_pronto,
  input  logic        porta_ocupada,
  output logic [31:0] Dado,
  output logic [8:0]  RegEscrita,
  output logic        FlagEscrita,
  output logic [4:0]  ocupacao,
  output logic [31:0] pendente,
  output logic        erro_reg
);

  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  // Entry storage. Only in-range destinations are ever stored, so five
  // address bits per entry are enough.
  logic [31:0]              dadoMem [PROFUNDIDADE];
  logic [4:0]               regMem  [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0]  validoReg, validoNext;
  logic [PW-1:0]            cabecaReg, caudaReg;
  logic [4:0]               ocupacaoReg, ocupacaoNext;
  logic                     erroReg;

  logic        cheio, vazio;
  logic        aceite, entradaNoIntervalo;
  logic [31:0] entradaDado;
  logic [8:0]  entradaReg;
  logic        enfileira, desenfileira, usaBypass;
  logic [31:0] mascaraEntrada [PROFUNDIDADE];

  assign cheio = (ocupacaoReg == 5'(PROFUNDIDADE));
  assign vazio = (ocupacaoReg == 5'd0);

  // Ready depends only on registered fullness and the higher-priority valids;
  // everything is held off while reset is asserted.
  assign mem_pronto = !reset && !cheio;
  assign jal_pronto = !reset && !cheio && !mem_valido;
  assign ula_pronto = !reset && !cheio && !mem_valido && !jal_valido;

  // Select the single producer that completes its handshake this cycle.
  always_comb begin
    aceite      = 1'b0;
    entradaDado = 32'd0;
    entradaReg  = 9'd0;
    if (mem_valido && mem_pronto) begin
      aceite      = 1'b1;
      entradaDado = mem_dado;
      entradaReg  = mem_reg;
    end else if (jal_valido && jal_pronto) begin
      aceite      = 1'b1;
      entradaDado = jal_pc;
      entradaReg  = jal_reg;
    end else if (ula_valido && ula_pronto) begin
      aceite      = 1'b1;
      entradaDado = ula_dado;
      entradaReg  = ula_reg;
    end
  end

  assign entradaNoIntervalo = (entradaReg[8:5] == 4'd0);

  // The head leaves only when the port is free; reset discards it instead.
  assign desenfileira = !vazio && !porta_ocupada && !reset;

`ifdef ESCRITA_BYPASS_EN
  assign usaBypass = vazio && !porta_ocupada && aceite && entradaNoIntervalo;
`else
  assign usaBypass = 1'b0;
`endif

  // Out-of-range entries complete the handshake but are dropped here.
  assign enfileira = aceite && entradaNoIntervalo && !usaBypass;

  // Bank write port: head entry, bypassed entry, or all zeros.
  always_comb begin
    FlagEscrita = 1'b0;
    Dado        = 32'd0;
    RegEscrita  = 9'd0;
    if (desenfileira) begin
      FlagEscrita = 1'b1;
      Dado        = dadoMem[cabecaReg];
      RegEscrita  = {4'd0, regMem[cabecaReg]};
    end else if (usaBypass) begin
      FlagEscrita = 1'b1;
      Dado        = entradaDado;
      RegEscrita  = entradaReg;
    end
  end

  // Next valid map and occupancy. Push and pop never hit the same slot:
  // push needs a non-full FIFO and pop a non-empty one.
  always_comb begin
    validoNext = validoReg;
    if (desenfileira) validoNext[cabecaReg] = 1'b0;
    if (enfileira)    validoNext[caudaReg]  = 1'b1;
    ocupacaoNext = ocupacaoReg + {4'd0, enfileira} - {4'd0, desenfileira};
  end

  // Control state: pointers, occupancy, valid bits and the sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      cabecaReg   <= '0;
      caudaReg    <= '0;
      ocupacaoReg <= 5'd0;
      validoReg   <= '0;
      erroReg     <= 1'b0;
    end else begin
      if (desenfileira) cabecaReg <= PW'((32'(cabecaReg) + 1) % PROFUNDIDADE);
      if (enfileira)    caudaReg  <= PW'((32'(caudaReg) + 1) % PROFUNDIDADE);
      ocupacaoReg <= ocupacaoNext;
      validoReg   <= validoNext;
      if (aceite && !entradaNoIntervalo) erroReg <= 1'b1;
    end
  end

  // Entry payload; no reset needed because the valid bits qualify it.
  always_ff @(posedge clock) begin
    if (enfileira) begin
      dadoMem[caudaReg] <= entradaDado;
      regMem[caudaReg]  <= entradaReg[4:0];
    end
  end

  // One-hot destination mask per slot, zero for empty slots.
  genvar gi;
  generate
    for (gi = 0; gi < PROFUNDIDADE; gi++) begin : gMascara
      assign mascaraEntrada[gi] = validoReg[gi] ? (32'd1 << regMem[gi]) : 32'd0;
    end
  endgenerate

  // Pending vector is the OR of all slot masks.
  always_comb begin
    pendente = 32'd0;
    for (int e = 0; e < PROFUNDIDADE; e++) pendente = pendente | mascaraEntrada[e];
  end

  assign ocupacao = ocupacaoReg;
  assign erro_reg = erroReg;

endmodule

// File: tb/tb_controle_escrita_banco.sv
// tb_controle_escrita_banco
// Cycle table of {inputs, expected outputs} for controle_escrita_banco with
// PROFUNDIDADE=4 (default build, no ESCRITA_BYPASS_EN), plus hand-written
// sequences for reset and write latency.
module tb_controle_escrita_banco;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valido, jal_valido, ula_valido;
  logic [31:0] mem_dado, jal_pc, ula_dado;
  logic [8:0]  mem_reg, jal_reg, ula_reg;
  logic        mem_pronto, jal_pronto, ula_pronto;
  logic        porta_ocupada;
  logic [31:0] Dado;
  logic [8:0]  RegEscrita;
  logic        FlagEscrita;
  logic [4:0]  ocupacao;
  logic [31:0] pendente;
  logic        erro_reg;

  int checkCount = 0;
  int passCount  = 0;

  controle_escrita_banco #(.PROFUNDIDADE(4)) dut (
    .clock(clock), .reset(reset),
    .mem_valido(mem_valido), .mem_dado(mem_dado), .mem_reg(mem_reg), .mem_pronto(mem_pronto),
    .jal_valido(jal_valido), .jal_pc(jal_pc), .jal_reg(jal_reg), .jal_pronto(jal_pronto),
    .ula_valido(ula_valido), .ula_dado(ula_dado), .ula_reg(ula_reg), .ula_pronto(ula_pronto),
    .porta_ocupada(porta_ocupada),
    .Dado(Dado), .RegEscrita(RegEscrita), .FlagEscrita(FlagEscrita),
    .ocupacao(ocupacao), .pendente(pendente), .erro_reg(erro_reg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        busy;
    logic        mV; logic [8:0] mR; logic [31:0] mD;
    logic        jV; logic [8:0] jR; logic [31:0] jD;
    logic        uV; logic [8:0] uR; logic [31:0] uD;
    logic [2:0]  eP;      // {mem_pronto, jal_pronto, ula_pronto}
    logic        eF;
    logic [8:0]  eR;
    logic [31:0] eD;
    logic [4:0]  eO;
    logic [31:0] ePend;
    logic        eE;
  } vetor_t;

  vetor_t tabela[$];

  task automatic add(input logic rst, input logic busy,
                     input logic mV, input logic [8:0] mR, input logic [31:0] mD,
                     input logic jV, input logic [8:0] jR, input logic [31:0] jD,
                     input logic uV, input logic [8:0] uR, input logic [31:0] uD,
                     input logic [2:0] eP, input logic eF, input logic [8:0] eR,
                     input logic [31:0] eD, input logic [4:0] eO,
                     input logic [31:0] ePend, input logic eE);
    vetor_t v;
    v.rst = rst; v.busy = busy;
    v.mV = mV; v.mR = mR; v.mD = mD;
    v.jV = jV; v.jR = jR; v.jD = jD;
    v.uV = uV; v.uR = uR; v.uD = uD;
    v.eP = eP; v.eF = eF; v.eR = eR; v.eD = eD; v.eO = eO; v.ePend = ePend; v.eE = eE;
    tabela.push_back(v);
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checkCount++;
    if (atual === esperado) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
  endtask

  task automatic idleInputs();
    mem_valido = 0; mem_reg = 0; mem_dado = 0;
    jal_valido = 0; jal_reg = 0; jal_pc = 0;
    ula_valido = 0; ula_reg = 0; ula_dado = 0;
    porta_ocupada = 0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    idleInputs();

    // Idle row shorthand: all producers quiet.
    // --- single ULA write, latency 1 ---
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    add(0,0, 0,0,0, 0,0,0, 1,5,32'hDEADBEEF,   3'b111,0,0,0,            0,32'h0,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,5,32'hDEADBEEF, 1,32'h20,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    // --- all three producers at once: mem, jal, ula ---
    add(0,0, 1,1,32'hA1, 1,2,32'hA2, 1,3,32'hA3, 3'b100,0,0,0,         0,32'h0,0);
    add(0,0, 0,0,0,      1,2,32'hA2, 1,3,32'hA3, 3'b110,1,1,32'hA1,    1,32'h2,0);
    add(0,0, 0,0,0,      0,0,0,      1,3,32'hA3, 3'b111,1,2,32'hA2,    1,32'h4,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,3,32'hA3,       1,32'h8,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    // --- port busy for 6 cycles while ULA pushes regs 0..5 ---
    add(0,1, 0,0,0, 0,0,0, 1,0,32'h100,        3'b111,0,0,0,            0,32'h0,0);
    add(0,1, 0,0,0, 0,0,0, 1,1,32'h101,        3'b111,0,0,0,            1,32'h1,0);
    add(0,1, 0,0,0, 0,0,0, 1,2,32'h102,        3'b111,0,0,0,            2,32'h3,0);
    add(0,1, 0,0,0, 0,0,0, 1,3,32'h103,        3'b111,0,0,0,            3,32'h7,0);
    add(0,1, 0,0,0, 0,0,0, 1,4,32'h104,        3'b000,0,0,0,            4,32'hF,0);
    add(0,1, 0,0,0, 0,0,0, 1,4,32'h104,        3'b000,0,0,0,            4,32'hF,0);
    add(0,0, 0,0,0, 0,0,0, 1,4,32'h104,        3'b000,1,0,32'h100,      4,32'hF,0);
    add(0,0, 0,0,0, 0,0,0, 1,4,32'h104,        3'b111,1,1,32'h101,      3,32'hE,0);
    add(0,0, 0,0,0, 0,0,0, 1,5,32'h105,        3'b111,1,2,32'h102,      3,32'h1C,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,3,32'h103,      3,32'h38,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,4,32'h104,      2,32'h30,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,5,32'h105,      1,32'h20,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    // --- two writes to reg 7, oldest drains first ---
    add(0,1, 0,0,0, 0,0,0, 1,7,32'h11,         3'b111,0,0,0,            0,32'h0,0);
    add(0,1, 0,0,0, 0,0,0, 1,7,32'h22,         3'b111,0,0,0,            1,32'h80,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,7,32'h11,       2,32'h80,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,7,32'h22,       1,32'h80,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    // --- out-of-range destination: accepted, dropped, sticky error ---
    add(0,0, 1,9'h040,32'h55, 0,0,0, 0,0,0,    3'b100,0,0,0,            0,32'h0,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,1);
    add(0,0, 0,0,0, 0,0,0, 1,9,32'h99,         3'b111,0,0,0,            0,32'h0,1);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,1,9,32'h99,       1,32'h200,1);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,1);
    // --- reset with 3 entries queued: none is ever written ---
    add(0,1, 0,0,0, 0,0,0, 1,10,32'hB0,        3'b111,0,0,0,            0,32'h0,1);
    add(0,1, 0,0,0, 0,0,0, 1,11,32'hB1,        3'b111,0,0,0,            1,32'h400,1);
    add(0,1, 0,0,0, 0,0,0, 1,12,32'hB2,        3'b111,0,0,0,            2,32'hC00,1);
    add(1,0, 0,0,0, 0,0,0, 0,0,0,              3'b000,0,0,0,            3,32'h1C00,1);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,0,              3'b111,0,0,0,            0,32'h0,0);

    // Initial reset: two edges, then outputs quiet while reset is still high.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pronto", {29'd0, mem_pronto, jal_pronto, ula_pronto}, 32'd0);
    chk("rst_flag", {31'd0, FlagEscrita}, 32'd0);
    chk("rst_ocup", {27'd0, ocupacao}, 32'd0);
    chk("rst_pend", pendente, 32'd0);
    reset = 1'b0;

    foreach (tabela[i]) begin
      vetor_t v;
      v = tabela[i];
      reset = v.rst; porta_ocupada = v.busy;
      mem_valido = v.mV; mem_reg = v.mR; mem_dado = v.mD;
      jal_valido = v.jV; jal_reg = v.jR; jal_pc = v.jD;
      ula_valido = v.uV; ula_reg = v.uR; ula_dado = v.uD;
      #2;
      chk($sformatf("v%0d_pronto", i), {29'd0, mem_pronto, jal_pronto, ula_pronto}, {29'd0, v.eP});
      chk($sformatf("v%0d_flag", i), {31'd0, FlagEscrita}, {31'd0, v.eF});
      chk($sformatf("v%0d_reg", i), {23'd0, RegEscrita}, {23'd0, v.eR});
      chk($sformatf("v%0d_dado", i), Dado, v.eD);
      chk($sformatf("v%0d_ocup", i), {27'd0, ocupacao}, {27'd0, v.eO});
      chk($sformatf("v%0d_pend", i), pendente, v.ePend);
      chk($sformatf("v%0d_erro", i), {31'd0, erro_reg}, {31'd0, v.eE});
      $display("vec %0d: rst=%0b busy=%0b flag=%0b reg=%0d dado=0x%0h ocup=%0d pend=0x%0h erro=%0b",
               i, v.rst, v.busy, FlagEscrita, RegEscrita, Dado, ocupacao, pendente, erro_reg);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    idleInputs();

    // Latency: a single accepted write appears on the port right after its edge.
    ula_valido = 1; ula_reg = 9'd20; ula_dado = 32'hCAFE;
    @(posedge clock);
    #1;
    idleInputs();
    lat = 0;
    while (!FlagEscrita && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("lat_ciclos", 32'(lat), 32'd0);
    chk("lat_reg", {23'd0, RegEscrita}, 32'd20);
    chk("lat_dado", Dado, 32'hCAFE);
    $display("latency write: reg=%0d dado=0x%0h extra_cycles=%0d", RegEscrita, Dado, lat);
    @(posedge clock);
    #1;
    chk("lat_apos_flag", {31'd0, FlagEscrita}, 32'd0);
    chk("lat_apos_ocup", {27'd0, ocupacao}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/controle_escrita_banco.md
# controle_escrita_banco

Write-back sequencer sitting directly upstream of the register bank. Accepts results from three producers: ULA result, memory load data, and jump-and-link return address. Each producer uses a valid/ready handshake. Accepted writes are queued in a small FIFO and drained as one write per cycle on the bank's single `Dado`/`RegEscrita`/`FlagEscrita` write path. It also exports a per-register pending vector for upstream hazard checks.

## Interface
- `PROFUNDIDADE`, 4: FIFO depth in entries; power of two, 2..16.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valido`  in  1  load result available.
- `mem_dado`  in  32  load data.
- `mem_reg`  in  9  destination register.
- `mem_pronto`  out  1  load result accepted this edge when `mem_valido`=1.
- `jal_valido`, `jal_pc`(32), `jal_reg`(9), `jal_pronto`: same roles for jump-and-link.
- `ula_valido`, `ula_dado`(32), `ula_reg`(9), `ula_pronto`: same roles for ULA result.
- `porta_ocupada`  in  1  bank write port in use by another path this cycle; inhibits drain.
- `Dado`  out  32  write data to bank.
- `RegEscrita`  out  9  write address to bank.
- `FlagEscrita`  out  1  write strobe to bank; bank writes on the edge where it is 1.
- `ocupacao`  out  5  number of queued entries, 0..PROFUNDIDADE.
- `pendente`  out  32  bit r = 1 iff a queued entry targets register r.
- `erro_reg`  out  1  sticky; set when an entry with `reg[8:5]`≠0 is accepted.

## Operation
- At most one producer is accepted per cycle. Fixed priority: memory > jal > ula.
- `X_pronto` = `!cheio` and no higher-priority `valido` asserted. Ready is combinational from registered state and inputs.
- A transfer occurs when `X_valido` and `X_pronto` are both 1 at a rising edge. The entry {data, reg} is written at the tail.
- Producers hold data stable while `valido`=1 and `pronto`=0. A lower-priority producer may be starved indefinitely; this is allowed.
- Out-of-range destination (`reg[8:5]`≠0):
  - entry is accepted (handshake completes) but not queued;
  - `erro_reg` is set and stays set until `reset`.
- Drain: when the FIFO is non-empty and `porta_ocupada`=0:
  - `FlagEscrita`=1; `Dado` and `RegEscrita` come from the head entry;
  - the head is popped at that edge.
- When no write occurs, `FlagEscrita`=0 and `Dado`/`RegEscrita` drive 0.
- Enqueue and dequeue may happen on the same edge; `ocupacao` is then unchanged. Enqueue when full is impossible, because `pronto`=0 when full.
- Order is strict FIFO. Two queued writes to the same register drain oldest first, so the bank ends with the newest value.
- `pendente` is the OR over valid entries of the one-hot of `reg[4:0]`, computed from FIFO contents, so it updates the cycle after enqueue or dequeue.
- Pointers are log2(PROFUNDIDADE) bits and wrap modulo PROFUNDIDADE. `ocupacao` distinguishes full from empty.

## Timing
- Reset (`reset`=1 at an edge) sets:
  - pointers and `ocupacao` to 0; all entries invalid;
  - `erro_reg`=0, `pendente`=0, `FlagEscrita`=0, `Dado`=0, `RegEscrita`=0.
- While `reset`=1 all `pronto` outputs are 0. Entries queued before reset are discarded, never written.
- Latency without bypass: an entry accepted at edge N into an empty FIFO has `FlagEscrita`=1 during cycle N+1 and is written at edge N+1.
- Sustained throughput is 1 write per cycle while `porta_ocupada`=0.
- `porta_ocupada`=1 holds the head. `FlagEscrita`=0 for that cycle and no entry is lost.

## Configuration
- `ESCRITA_BYPASS_EN` defined:
  - when the FIFO is empty, `porta_ocupada`=0 and a valid in-range transfer occurs, that entry drives `Dado`/`RegEscrita`/`FlagEscrita` combinationally in the same cycle;
  - the bank writes it at edge N (latency 0) and it is not enqueued;
  - `pendente` is unaffected by a bypassed entry.
- `ESCRITA_BYPASS_EN` not defined: every write goes through the FIFO with latency 1 as above.

## Test plan
- After reset, `ula_valido`=1, `ula_reg`=5, `ula_dado`=0xDEADBEEF at edge 1 → `FlagEscrita`=1, `RegEscrita`=5, `Dado`=0xDEADBEEF during cycle 2 (cycle 1 with bypass); `pendente[5]`=1 for one cycle without bypass.
- All three producers valid in one cycle with registers 1/2/3 → accepted in order mem, jal, ula on successive edges; bank writes regs 1, 2, 3 in that order; `ula_pronto`=0 until memory and jal are done.
- `porta_ocupada`=1 for 6 cycles while the ULA pushes regs 0..5 with PROFUNDIDADE=4 → `ocupacao` reaches 4, `ula_pronto`=0 when full. After release, writes drain 0,1,2,3 then 4,5 with no loss.
- Two queued writes to reg 7 (0x11 then 0x22) → drained 0x11 then 0x22; `pendente[7]` clears only after the second pops.
- `mem_reg`=0x040 → handshake completes, no `FlagEscrita`, `erro_reg`=1 and sticky; later valid writes are unaffected.
- `reset` asserted with 3 entries queued → next cycle `ocupacao`=0, `pendente`=0, `FlagEscrita`=0, `erro_reg`=0; none of the 3 entries is ever written.
